// File: rtl/wb_burst_master_if.sv
// Command, write-stream, read-stream and Wishbone B3 signals of wb_burst_master.
// master = burst-master view; slave = view of whatever drives the master's inputs.
interface wb_burst_master_if #(
  parameter int dw = 32,
  parameter int aw = 32,
  parameter int lw = 5
);
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [aw-1:0] cmd_adr_i;
  logic [lw-1:0] cmd_len_i;
  logic          cmd_we_i;

  logic [dw-1:0] wr_dat_i;
  logic          wr_valid_i;
  logic          wr_ready_o;

  logic [dw-1:0] rd_dat_o;
  logic          rd_valid_o;
  logic          done_o;
  logic          err_o;

  logic [aw-1:0]   wb_adr_o;
  logic [dw-1:0]   wb_dat_o;
  logic [dw/8-1:0] wb_sel_o;
  logic            wb_we_o;
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic [2:0]      wb_cti_o;
  logic [1:0]      wb_bte_o;
  logic [dw-1:0]   wb_dat_i;
  logic            wb_ack_i;
  logic            wb_err_i;

  modport master (
    input  cmd_valid_i, cmd_adr_i, cmd_len_i, cmd_we_i, wr_dat_i, wr_valid_i,
           wb_dat_i, wb_ack_i, wb_err_i,
    output cmd_ready_o, wr_ready_o, rd_dat_o, rd_valid_o, done_o, err_o,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
  );

  modport slave (
    output cmd_valid_i, cmd_adr_i, cmd_len_i, cmd_we_i, wr_dat_i, wr_valid_i,
           wb_dat_i, wb_ack_i, wb_err_i,
    input  cmd_ready_o, wr_ready_o, rd_dat_o, rd_valid_o, done_o, err_o,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 master: one command -> one classic or linear incrementing burst cycle.
// Optional bus watchdog enabled by defining WB_BURST_MASTER_TIMEOUT_EN.
module wb_burst_master #(
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int MAX_BURST = 16,
  parameter int lw        = $clog2(MAX_BURST + 1),
  parameter int TIMEOUT   = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_burst_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [aw-1:0] ADR_STEP = aw'(dw / 8);
  localparam logic [aw-1:0] ADR_LSB  = aw'(dw / 8 - 1);

  state_t        state_q, state_d;
  logic [aw-1:0] adr_q, adr_d;
  logic [lw-1:0] rem_q, rem_d;
  logic          we_q, we_d;
  logic          single_q, single_d;
  logic          err_q, err_d;
  logic [dw-1:0] rd_dat_q, rd_dat_d;
  logic          rd_valid_q, rd_valid_d;
  logic [lw-1:0] len_eff;

  logic stb;
  logic beat_ack;
  logic beat_err;
  logic wdog_fire;

  assign stb      = (state_q == BUS) && (we_q ? bus.wr_valid_i : 1'b1);
  assign beat_err = stb && bus.wb_err_i;
  assign beat_ack = stb && bus.wb_ack_i && !bus.wb_err_i;

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wdog_q, wdog_d;

  // Counter is held at zero outside BUS, so entry to BUS always starts from a clean count.
  always_comb begin
    wdog_d    = wdog_q;
    wdog_fire = 1'b0;
    if (state_q != BUS) begin
      wdog_d = '0;
    end else if (stb && (bus.wb_ack_i || bus.wb_err_i)) begin
      wdog_d = '0;
    end else if (stb) begin
      if (wdog_q == TW'(TIMEOUT - 1)) begin
        wdog_fire = 1'b1;
      end else begin
        wdog_d = wdog_q + TW'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) wdog_q <= '0;
    else          wdog_q <= wdog_d;
  end
`else
  assign wdog_fire = 1'b0;
`endif

  always_comb begin
    len_eff = bus.cmd_len_i;
    if (bus.cmd_len_i == '0)                  len_eff = lw'(1);
    else if (bus.cmd_len_i > lw'(MAX_BURST))  len_eff = lw'(MAX_BURST);
  end

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    rem_d      = rem_q;
    we_d       = we_q;
    single_d   = single_q;
    err_d      = err_q;
    rd_dat_d   = rd_dat_q;
    rd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (bus.cmd_valid_i) begin
          adr_d    = bus.cmd_adr_i & ~ADR_LSB;
          rem_d    = len_eff;
          single_d = (len_eff == lw'(1));
          we_d     = bus.cmd_we_i;
          state_d  = BUS;
        end
      end
      BUS: begin
        if (beat_err || wdog_fire) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (beat_ack) begin
          rem_d = rem_q - lw'(1);
          adr_d = adr_q + ADR_STEP;
          if (!we_q) begin
            rd_valid_d = 1'b1;
            rd_dat_d   = bus.wb_dat_i;
          end
          if (rem_q == lw'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      rem_q      <= '0;
      we_q       <= 1'b0;
      single_q   <= 1'b0;
      err_q      <= 1'b0;
      rd_dat_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      rem_q      <= rem_d;
      we_q       <= we_d;
      single_q   <= single_d;
      err_q      <= err_d;
      rd_dat_q   <= rd_dat_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // cti is derived from the remaining count, so it only moves on the edge after an ack.
  always_comb begin
    bus.wb_cti_o = 3'b000;
    if ((state_q == BUS) && !single_q) begin
      bus.wb_cti_o = (rem_q == lw'(1)) ? 3'b111 : 3'b010;
    end
  end

  assign bus.cmd_ready_o = (state_q == IDLE);
  assign bus.wr_ready_o  = beat_ack && we_q;
  assign bus.rd_dat_o    = rd_dat_q;
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.done_o      = (state_q == DONE);
  assign bus.err_o       = (state_q == DONE) && err_q;
  assign bus.wb_adr_o    = adr_q;
  assign bus.wb_dat_o    = bus.wr_dat_i;
  assign bus.wb_sel_o    = '1;
  assign bus.wb_we_o     = we_q;
  assign bus.wb_cyc_o    = (state_q == BUS);
  assign bus.wb_stb_o    = stb;
  assign bus.wb_bte_o    = 2'b00;

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
Wishbone B3 initiator that turns a single command (start address, beat count, direction) into one classic or linear incrementing-burst cycle on the system bus. It is the master counterpart of the on-chip Wishbone RAM/peripheral responders, and is used by DMA and test-harness logic. Write data is pulled from a valid/ready stream. Read data is pushed out as single-cycle valid pulses.

Parameters:
dw, 32, Wishbone data width in bits (multiple of 8).
aw, 32, Wishbone byte-address width.
MAX_BURST, 16, maximum beats per command (≥1).
lw, $clog2(MAX_BURST+1), width of the beat-count field.
TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
wb_clk_i  in  1  clock; all logic on the rising edge
wb_rst_i  in  1  reset, asynchronous, active-high
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  high only in IDLE; command accepted when valid&ready
cmd_adr_i  in  aw  start byte address; low $clog2(dw/8) bits forced to 0 internally
cmd_len_i  in  lw  beat count, 1..MAX_BURST
cmd_we_i  in  1  1=write burst, 0=read burst
wr_dat_i  in  dw  write stream data
wr_valid_i  in  1  write data available
wr_ready_o  out  1  write beat consumed (=wb_stb_o & wb_we_o & wb_ack_i)
rd_dat_o  out  dw  read data, registered
rd_valid_o  out  1  one-cycle pulse per acked read beat; no backpressure
done_o  out  1  one-cycle pulse when the cycle ends (normal or error)
err_o  out  1  one-cycle pulse coincident with done_o when ended by error
wb_adr_o  out  aw  bus address
wb_dat_o  out  dw  bus write data (=wr_dat_i)
wb_sel_o  out  dw/8  byte selects, all ones
wb_we_o  out  1  write enable, latched command direction
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_cti_o  out  3  cycle type
wb_bte_o  out  2  burst type, constant 2'b00 (linear)
wb_dat_i  in  dw  bus read data
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  error termination

Behaviour:
- Reset values: wb_cyc_o, wb_stb_o, wb_we_o, rd_valid_o, done_o, err_o = 0. wb_adr_o, rd_dat_o = 0. wb_cti_o = 3'b000. FSM = IDLE. Beat counter = 0.
- FSM states are IDLE, BUS, DONE.
- IDLE: cmd_ready_o=1. On accept, latch address, length and we; go to BUS next cycle with wb_cyc_o=1. cmd_len_i=0 is treated as 1.
- BUS, strobe and address:
  - wb_stb_o = 1 for reads.
  - wb_stb_o = wr_valid_i for writes; a low wr_valid_i inserts a wait state with cyc held and adr/cti unchanged.
  - A beat completes on wb_stb_o & wb_ack_i. The remaining-count register decrements and wb_adr_o advances by dw/8 (wraps modulo 2^aw).
- BUS, cycle type:
  - Length 1: wb_cti_o = 3'b000 (classic).
  - Otherwise: 3'b010 on every beat except the last, and 3'b111 while the last beat is outstanding.
  - cti changes only at the edge following an ack.
- Read beats: rd_dat_o <= wb_dat_i and rd_valid_o=1 the cycle after the ack, i.e. a 1-cycle registered output latency.
- Normal end: on the ack of the last beat, go to DONE. wb_cyc_o and wb_stb_o are low from the next cycle, with no extra strobe after the final ack.
- Error end: wb_err_i while in BUS with stb high terminates immediately. There is no further beat, no rd_valid for that beat, and no wr_ready. Go to DONE with err_o.
- wb_ack_i and wb_err_i are ignored while wb_stb_o=0 or in IDLE/DONE.
- DONE: done_o=1 (plus err_o if applicable) for one cycle, then IDLE. The next command is accepted no earlier than the cycle after DONE.
- Asserting reset mid-burst drops cyc/stb asynchronously. Partial beats are lost and no done_o is generated.

Optional Feature:
WB_BURST_MASTER_TIMEOUT_EN
- Defined: a watchdog counter clears on every ack/err and on entry to BUS, and increments each BUS cycle with stb high. On reaching TIMEOUT, the FSM terminates exactly as for wb_err_i (done_o+err_o pulse).
- Undefined: no counter is present, and BUS waits indefinitely for ack/err.

Test Plan:
- Read, len=1, adr=0x100; responder acks after 1 cycle → one beat with cti=000, adr=0x100, one rd_valid pulse with the returned data, done_o 1 cycle later, err_o=0.
- Read, len=4, adr=0x40; zero-wait responder → cti sequence 010,010,010,111; adr 0x40,0x44,0x48,0x4C; four rd_valid pulses in order; cyc low the cycle after the 4th ack.
- Write, len=3; wr_valid_i low for 2 cycles before the 2nd beat → stb low for those cycles, cyc held, adr=base+4 held; exactly 3 wr_ready pulses; responder RAM contains the 3 words.
- Write, len=8; wb_err_i on the 3rd beat → 2 wr_ready pulses only; cyc/stb low next cycle; done_o and err_o pulse together; cmd_ready_o high afterwards.
- Read, len=4, adr=0xFFFFFFF8 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; reset asserted during beat 3 → cyc/stb 0 immediately, no done_o.
- With WB_BURST_MASTER_TIMEOUT_EN, TIMEOUT=10, non-responding slave → done_o and err_o after 10 strobed cycles; without the macro, cyc stays high for 1000 cycles.
